mem_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage. Registers the execute-stage results, performs loads and stores to data memory over a req/ack handshake, and formats byte, halfword and word data. Stalls upstream while a memory access is outstanding, and presents writeback controls plus the MEM-stage ALU result for forwarding back into execute.

---
 rtl/mem_stage.sv | 208 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers execute results, runs one req/ack data
// memory access per load/store, and formats big-endian byte/halfword/word data.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dMemWr,
    input  logic        dMemToReg,
    input  logic        dRegWrite,
    input  logic        dJal,
    input  logic        dLoadext,
    input  logic [1:0]  dDsize,
    input  logic [31:0] dALUout,
    input  logic [31:0] dBusB,
    input  logic [31:0] dDelayslot2,
    input  logic [4:0]  dRw,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        RegWr,
    output logic        MemToReg,
    output logic        Jal,
    output logic [4:0]  Rw,
    output logic [31:0] ALUresult,
    output logic [31:0] MemData,
    output logic [31:0] Delayslot2,
    output logic        misalign
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        case (size)
            2'b01:   res = off[0];
            2'b10:   res = 1'b0;
            default: res = (off != 2'b00);
        endcase
        return res;
    endfunction

    function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b01:   be = off[1] ? 4'b0011 : 4'b1100;
            2'b10:   be = 4'b1000 >> off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] busb);
        logic [31:0] wd;
        case (size)
            2'b01:   wd = {2{busb[15:0]}};
            2'b10:   wd = {4{busb[7:0]}};
            default: wd = busb;
        endcase
        return wd;
    endfunction

    // Offset 0 is the most significant lane (big-endian).
    function automatic logic [31:0] f_load_data(input logic [1:0] size, input logic [1:0] off,
                                                input logic ext, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'b00:   b = rdata[31:24];
            2'b01:   b = rdata[23:16];
            2'b10:   b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = off[1] ? rdata[15:0] : rdata[31:16];
        case (size)
            2'b01:   res = {{16{ext & h[15]}}, h};
            2'b10:   res = {{24{ext & b[7]}}, b};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic [1:0]  r_state;
    logic        r_mem_wr;
    logic        r_mem_to_reg;
    logic        r_reg_write;
    logic        r_jal;
    logic        r_loadext;
    logic [1:0]  r_dsize;
    logic [31:0] r_alu;
    logic [31:0] r_ds2;
    logic [4:0]  r_rw;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic        r_reg_wr;
    logic        r_misalign;
    logic [31:0] r_mem_data;

    logic        w_stall;
    logic        w_is_mem;
    logic        w_mis;
    logic        w_go_req;
    logic        w_is_load;
    logic [31:0] w_load_data;

    assign w_stall     = (r_state == ST_REQ);
    assign w_is_mem    = dMemWr | dMemToReg;
    assign w_mis       = w_is_mem & f_misaligned(dDsize, dALUout[1:0]);
    assign w_go_req    = w_is_mem & ~w_mis;
    assign w_is_load   = r_mem_to_reg & ~r_mem_wr;
    assign w_load_data = f_load_data(r_dsize, r_alu[1:0], r_loadext, mem_rdata);

    // Execute-stage capture register; frozen while an access is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_wr     <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_jal        <= 1'b0;
            r_loadext    <= 1'b0;
            r_dsize      <= 2'b00;
            r_alu        <= 32'h0000_0000;
            r_ds2        <= 32'h0000_0000;
            r_rw         <= 5'd0;
        end else if (!w_stall) begin
            r_mem_wr     <= dMemWr;
            r_mem_to_reg <= dMemToReg;
            r_reg_write  <= dRegWrite;
            r_jal        <= dJal;
            r_loadext    <= dLoadext;
            r_dsize      <= dDsize;
            r_alu        <= dALUout;
            r_ds2        <= dDelayslot2;
            r_rw         <= dRw;
        end
    end

    // Access FSM; DONE is only a marker and decides the next capture like IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (!w_stall) begin
            r_state <= w_go_req ? ST_REQ : ST_IDLE;
        end else if (mem_ack) begin
            r_state <= ST_DONE;
        end else begin
            r_state <= ST_REQ;
        end
    end

    // Request attributes are fixed at capture so they stay constant through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
        end else if (!w_stall) begin
            r_mem_we    <= dMemWr & w_go_req;
            r_mem_addr  <= {dALUout[31:2], 2'b00};
            r_mem_be    <= w_go_req ? f_byte_en(dDsize, dALUout[1:0]) : 4'b0000;
            r_mem_wdata <= f_store_data(dDsize, dBusB);
        end else if (mem_ack) begin
            r_mem_we    <= 1'b0;
        end
    end

    // Writeback qualifiers and load data; RegWr stays low for the whole request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_wr   <= 1'b0;
            r_misalign <= 1'b0;
            r_mem_data <= 32'h0000_0000;
        end else if (!w_stall) begin
            r_reg_wr   <= dRegWrite & ~w_mis & ~w_go_req;
            r_misalign <= w_mis;
        end else if (mem_ack) begin
            r_reg_wr   <= r_reg_write;
            if (w_is_load) begin
                r_mem_data <= w_load_data;
            end
        end
    end

    assign stall      = w_stall;
    assign mem_req    = w_stall;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign RegWr      = r_reg_wr;
    assign MemToReg   = r_mem_to_reg;
    assign Jal        = r_jal;
    assign Rw         = r_rw;
    assign ALUresult  = r_alu;
    assign MemData    = r_mem_data;
    assign Delayslot2 = r_ds2;
    assign misalign   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle compare against a behavioural model
// of the stage, plus hand-computed literal expectations for each vector.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dMemWr, dMemToReg, dRegWrite, dJal, dLoadext;
    logic [1:0]  dDsize;
    logic [31:0] dALUout, dBusB, dDelayslot2;
    logic [4:0]  dRw;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall, RegWr, MemToReg, Jal, misalign;
    logic [4:0]  Rw;
    logic [31:0] ALUresult, MemData, Delayslot2;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .dMemWr(dMemWr), .dMemToReg(dMemToReg), .dRegWrite(dRegWrite),
        .dJal(dJal), .dLoadext(dLoadext), .dDsize(dDsize),
        .dALUout(dALUout), .dBusB(dBusB), .dDelayslot2(dDelayslot2), .dRw(dRw),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .RegWr(RegWr), .MemToReg(MemToReg), .Jal(Jal), .Rw(Rw),
        .ALUresult(ALUresult), .MemData(MemData), .Delayslot2(Delayslot2),
        .misalign(misalign)
    );

    typedef struct {
        logic        mw, m2r, rw, jal, lext;
        logic [1:0]  sz;
        logic [31:0] alu, busb, ds2, rdata;
        logic [4:0]  rd;
        int          wt;
        logic        spur;
        int          lit_stalls;
        logic [3:0]  lit_be;
        logic [31:0] lit_addr, lit_wdata, lit_md;
        logic        lit_rw, lit_mis;
    } op_t;

    op_t ops[14];
    int  n_checks = 0;
    int  n_fail   = 0;

    logic        exp_valid, e_bus_chk;
    logic        e_stall, e_req, e_we, e_regwr, e_m2r, e_jal, e_mis;
    logic [31:0] e_addr, e_wdata, e_alu, e_md, e_ds2;
    logic [3:0]  e_be;
    logic [4:0]  e_rw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic f_mis(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 32'd4);
        if (sz == 2'd2) return 1'b0;
        if (sz == 2'd1) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 32'd4);
        if (sz == 2'd2) return 4'(1 << (3 - off));
        if (sz == 2'd1) return 4'(3 << (2 - off));
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] b);
        if (sz == 2'd2) return (b & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (b & 32'hFFFF) * 32'h0001_0001;
        return b;
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic ext, input logic [31:0] rd);
        int off = int'(a % 32'd4);
        logic [31:0] v;
        if (sz == 2'd2) begin
            v = (rd >> (8 * (3 - off))) & 32'hFF;
            if (ext && v >= 32'h80) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
            if (ext && v >= 32'h8000) v = v + 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    task automatic model_reset();
        e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_regwr = 1'b0;
        e_m2r = 1'b0; e_jal = 1'b0; e_mis = 1'b0; e_rw = 5'd0;
        e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0;
        e_alu = 32'h0; e_md = 32'h0; e_ds2 = 32'h0;
        e_bus_chk = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("RegWr", 32'(RegWr), 32'(e_regwr));
            chk("MemToReg", 32'(MemToReg), 32'(e_m2r));
            chk("Jal", 32'(Jal), 32'(e_jal));
            chk("Rw", 32'(Rw), 32'(e_rw));
            chk("ALUresult", ALUresult, e_alu);
            chk("MemData", MemData, e_md);
            chk("Delayslot2", Delayslot2, e_ds2);
            chk("misalign", 32'(misalign), 32'(e_mis));
            if (e_bus_chk) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_be", 32'(mem_be), 32'(e_be));
                chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    task automatic run_op(input op_t o, input int idx);
        logic ismem, mis, goreq;
        int   cnt;
        dMemWr = o.mw; dMemToReg = o.m2r; dRegWrite = o.rw; dJal = o.jal;
        dLoadext = o.lext; dDsize = o.sz; dALUout = o.alu; dBusB = o.busb;
        dDelayslot2 = o.ds2; dRw = o.rd;
        mem_ack = o.spur; mem_rdata = o.rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        ismem = o.mw | o.m2r;
        mis   = ismem & f_mis(o.sz, o.alu);
        goreq = ismem & ~mis;
        e_m2r = o.m2r; e_jal = o.jal; e_rw = o.rd; e_alu = o.alu; e_ds2 = o.ds2;
        e_mis = mis; e_stall = goreq; e_req = goreq; e_bus_chk = goreq;
        e_we = o.mw; e_addr = o.alu & 32'hFFFF_FFFC;
        e_be = f_be(o.sz, o.alu); e_wdata = f_wdata(o.sz, o.busb);
        e_regwr = o.rw & ~mis & ~goreq;
        cnt = 0;
        chk($sformatf("op%0d_lit_misalign", idx), 32'(misalign), 32'(o.lit_mis));
        if (goreq) begin
            chk($sformatf("op%0d_lit_be", idx), 32'(mem_be), 32'(o.lit_be));
            chk($sformatf("op%0d_lit_addr", idx), mem_addr, o.lit_addr);
            chk($sformatf("op%0d_lit_wdata", idx), mem_wdata, o.lit_wdata);
            for (int w = 0; w <= o.wt; w++) begin
                if (stall) cnt++;
                if (w == o.wt) begin
                    mem_ack = 1'b1; mem_rdata = o.rdata;
                end
                @(posedge clk); #1;
            end
            mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
            e_stall = 1'b0; e_req = 1'b0; e_bus_chk = 1'b0; e_regwr = o.rw;
            if (o.m2r && !o.mw) e_md = f_load(o.sz, o.alu, o.lext, o.rdata);
        end
        if (stall) cnt++;
        chk($sformatf("op%0d_lit_stalls", idx), 32'(cnt), 32'(o.lit_stalls));
        chk($sformatf("op%0d_lit_memdata", idx), MemData, o.lit_md);
        chk($sformatf("op%0d_lit_regwr", idx), 32'(RegWr), 32'(o.lit_rw));
    endtask

    initial begin
        //         mw   m2r  rw   jal  lext sz     alu            busb           ds2            rdata          rd    wt sp   st be     addr          wdata          memdata        rw   mis
        ops[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,32'h0000_0100,32'h0000_0000,32'h0000_0000,32'h89AB_CDEF,5'd5, 0,1'b0,1,4'hF,32'h0000_0100,32'h0000_0000,32'h89AB_CDEF,1'b1,1'b0};
        ops[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,2'd2,32'h0000_0103,32'h0000_0000,32'h0000_0000,32'h0000_00F0,5'd6, 3,1'b0,4,4'h1,32'h0000_0100,32'h0000_0000,32'hFFFF_FFF0,1'b1,1'b0};
        ops[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd2,32'h0000_0103,32'h0000_00C3,32'h0000_0000,32'h0000_00F0,5'd6, 3,1'b0,4,4'h1,32'h0000_0100,32'hC3C3_C3C3,32'h0000_00F0,1'b1,1'b0};
        ops[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,32'h0000_0202,32'h1234_ABCD,32'h0000_0000,32'h0000_0000,5'd2, 2,1'b0,3,4'h3,32'h0000_0200,32'hABCD_ABCD,32'h0000_00F0,1'b0,1'b0};
        ops[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,32'h0000_0101,32'h0000_0000,32'h0000_0000,32'hDEAD_BEEF,5'd4, 0,1'b1,0,4'h0,32'h0000_0000,32'h0000_0000,32'h0000_00F0,1'b0,1'b1};
        ops[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,32'h1111_1111,32'h0000_0000,32'h0000_0000,32'h7777_7777,5'd7, 0,1'b1,0,4'h0,32'h0000_0000,32'h0000_0000,32'h0000_00F0,1'b1,1'b0};
        ops[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,32'h2222_2223,32'h0000_0000,32'h0040_0008,32'h0000_0000,5'd8, 0,1'b0,0,4'h0,32'h0000_0000,32'h0000_0000,32'h0000_00F0,1'b1,1'b0};
        ops[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'd1,32'hFFFF_FFFF,32'h0000_0000,32'h0000_0000,32'h0000_0000,5'd9, 0,1'b0,0,4'h0,32'h0000_0000,32'h0000_0000,32'h0000_00F0,1'b1,1'b0};
        ops[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,2'd1,32'h0000_0306,32'h0000_0000,32'h0000_0000,32'h1234_8001,5'd10,1,1'b0,2,4'h3,32'h0000_0304,32'h0000_0000,32'hFFFF_8001,1'b1,1'b0};
        ops[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd1,32'h0000_0304,32'h0000_0000,32'h0000_0000,32'hBEEF_0000,5'd11,0,1'b0,1,4'hC,32'h0000_0304,32'h0000_0000,32'h0000_BEEF,1'b1,1'b0};
        ops[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd2,32'h0000_0401,32'h0000_00A5,32'h0000_0000,32'h0000_0000,5'd1, 0,1'b0,1,4'h4,32'h0000_0400,32'hA5A5_A5A5,32'h0000_BEEF,1'b0,1'b0};
        ops[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd3,32'h0000_0500,32'hCAFE_F00D,32'h0000_0000,32'h0000_0000,5'd1, 1,1'b0,2,4'hF,32'h0000_0500,32'hCAFE_F00D,32'h0000_BEEF,1'b0,1'b0};
        ops[12] = '{1'b0,1'b1,1'b1,1'b0,1'b1,2'd2,32'h0000_0102,32'h0000_0000,32'h0000_0000,32'h0080_7F00,5'd12,0,1'b0,1,4'h2,32'h0000_0100,32'h0000_0000,32'h0000_007F,1'b1,1'b0};
        ops[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,32'h0000_0700,32'h1122_3344,32'h0000_0000,32'h1357_9BDF,5'd13,1,1'b0,2,4'hF,32'h0000_0700,32'h1122_3344,32'h1357_9BDF,1'b1,1'b0};

        rst_n = 1'b0;
        dMemWr = 1'b0; dMemToReg = 1'b0; dRegWrite = 1'b0; dJal = 1'b0; dLoadext = 1'b0;
        dDsize = 2'd0; dALUout = 32'h0; dBusB = 32'h0; dDelayslot2 = 32'h0; dRw = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        model_reset();
        exp_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_op(ops[i], i);

        // Reset asserted in the middle of an outstanding word load.
        dMemWr = 1'b0; dMemToReg = 1'b1; dRegWrite = 1'b1; dJal = 1'b0; dLoadext = 1'b0;
        dDsize = 2'd0; dALUout = 32'h0000_0600; dBusB = 32'h0; dDelayslot2 = 32'h0; dRw = 5'd3;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        chk("rst_pre_stall", 32'(stall), 32'd1);
        chk("rst_pre_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        exp_valid = 1'b1;
        #1;
        chk("rst_req_drop", 32'(mem_req), 32'd0);
        chk("rst_stall_drop", 32'(stall), 32'd0);
        chk("rst_alu_zero", ALUresult, 32'd0);
        chk("rst_memdata_zero", MemData, 32'd0);
        chk("rst_rw_zero", 32'(Rw), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(ops[13], 13);
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
